input_port_fifo: RTL and testbench
==================================

// Module: input_port_fifo
// PURPOSE
//   Input-side peripheral mirroring the output register: external world pushes bytes in,
//   CPU pops them for the IN/INM instructions. Buffers up to DEPTH bytes in a small FIFO
//   with valid/ready handshake on the external side and a one-cycle pop strobe from the
//   control unit on the CPU side. Head byte is presented first-word-fall-through for the bus driver.
// PARAMETERS
//   DATA_WIDTH  8  width of each byte (matches arch_defs_pkg DATA_WIDTH)
//   DEPTH       4  FIFO entries; power of two, >= 2
// PORTS
//   clk          in   1           system clock; all state updates on rising edge
//   reset        in   1           synchronous, active-high reset
//   ext_data     in   DATA_WIDTH  byte offered by external source
//   ext_valid    in   1           ext_data is valid this cycle
//   ext_ready    out  1           block can accept a byte (= !full)
//   cpu_rd       in   1           control-unit pop strobe, one cycle wide
//   rd_data      out  DATA_WIDTH  head byte; 0 when empty
//   data_avail   out  1           FIFO non-empty (CPU flag/status bit)
//   full         out  1           count == DEPTH
//   overflow     out  1           sticky: byte dropped (only with INPUT_PORT_SYNC_EN)
//   clr_overflow in   1           clears overflow
// BEHAVIOUR
// - Reset: count=0, wr_ptr=rd_ptr=0, overflow=0 -> rd_data=0, data_avail=0, full=0, ext_ready=1.
//   Reset mid-transfer discards all contents; no byte accepted in a reset cycle.
// - Storage: DEPTH x DATA_WIDTH regs; ptrs width $clog2(DEPTH), wrap modulo DEPTH;
//   count width $clog2(DEPTH+1).
// - Push: ext_valid && ext_ready at edge -> mem[wr_ptr]<=ext_data, wr_ptr++.
//   Source holds ext_data/ext_valid stable while ext_ready=0; not an error.
// - Pop: cpu_rd && data_avail at edge -> rd_ptr++. cpu_rd while empty ignored, no state change.
// - Same-cycle push+pop (not empty, not full): both happen, count unchanged.
//   Empty + push + cpu_rd: push only (pop ignored). Full: ext_ready=0, pop only.
// - Outputs combinational from registered state: rd_data=mem[rd_ptr] when count!=0 else 0;
//   data_avail=(count!=0); full=(count==DEPTH); ext_ready=!full.
// - Latency: byte pushed at edge N visible on rd_data/data_avail after edge N (1 cycle);
//   after a pop at edge N, next byte (or 0) visible after edge N.
// - overflow: set on drop event (see CONFIGURATION); clr_overflow clears; set wins if same cycle.
// CONFIGURATION
// - INPUT_PORT_SYNC_EN defined: ext_valid treated as asynchronous strobe. ext_valid and
//   ext_data pass 2-flop synchronizer; rising edge of synced valid (3rd flop edge detect)
//   captures synced data. Capture while full drops byte and sets overflow. ext_ready
//   still reported but not honored by source. Latency ext_valid rise -> data_avail: 3 cycles.
//   Synchronizer flops reset to 0.
// - Not defined: plain synchronous valid/ready handshake as above; overflow tied 0;
//   clr_overflow unused.
// TESTING
// - Reset: assert reset 2 cycles -> data_avail=0, full=0, ext_ready=1, rd_data=8'h00, overflow=0.
// - Single byte: push 8'h0A, then cpu_rd -> rd_data=8'h0A one cycle after push; after pop data_avail=0, rd_data=0.
// - Fill: push 8'h11,22,33,44 -> full=1, ext_ready=0; hold 8'h55 valid 3 cycles -> not stored;
//   one pop -> rd_data=8'h22, ext_ready=1, 8'h55 then accepted; drain order 22,33,44,55.
// - Concurrent: count=2 (8'hA1,A2), push 8'hA3 with cpu_rd same cycle -> count stays 2, head 8'hA2;
//   cpu_rd on empty with push 8'h7E -> count=1, rd_data=8'h7E.
// - Wrap + reset: push/pop 10 bytes 8'h00..8'h09 interleaved -> read order preserved across ptr wrap;
//   reset with 3 bytes queued -> data_avail=0 next cycle, next push reads back correctly.
// - SYNC_EN build: 1-cycle ext_valid pulse with 8'hC3 -> data_avail rises 3 cycles later;
//   5 pulses with no pops -> 4 stored, overflow=1; clr_overflow -> overflow=0.

Source files
------------

// File: rtl/input_port_fifo.sv
// Input port FIFO: an external source pushes bytes in, and the CPU pops them for IN/INM.
// Define INPUT_PORT_SYNC_EN to treat ext_valid as an asynchronous strobe with a synchronizer.
module input_port_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ext_data,
    input  logic                  ext_valid,
    output logic                  ext_ready,
    input  logic                  cpu_rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  data_avail,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_count;

    logic                  w_pushReq;
    logic [DATA_WIDTH-1:0] w_pushData;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

`ifdef INPUT_PORT_SYNC_EN
    logic                  r_validSync1;
    logic                  r_validSync2;
    logic                  r_validSync3;
    logic [DATA_WIDTH-1:0] r_dataSync1;
    logic [DATA_WIDTH-1:0] r_dataSync2;
    logic                  r_overflow;

    // Two-flop synchronizer; the third valid flop only exists to find the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_validSync1 <= 1'b0;
            r_validSync2 <= 1'b0;
            r_validSync3 <= 1'b0;
            r_dataSync1  <= '0;
            r_dataSync2  <= '0;
        end else begin
            r_validSync1 <= ext_valid;
            r_validSync2 <= r_validSync1;
            r_validSync3 <= r_validSync2;
            r_dataSync1  <= ext_data;
            r_dataSync2  <= r_dataSync1;
        end
    end

    assign w_pushReq  = r_validSync2 && !r_validSync3;
    assign w_pushData = r_dataSync2;

    // The source ignores ext_ready here, so a capture while full is lost and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_pushReq && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unusedClr;

    assign w_pushReq   = ext_valid;
    assign w_pushData  = ext_data;
    assign overflow    = 1'b0;
    assign w_unusedClr = clr_overflow;
`endif

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_pushReq && !w_full;
    assign w_pop   = cpu_rd && !w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; an empty FIFO masks whatever the slots hold.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wrPtr] <= w_pushData;
        end
    end

    assign rd_data    = w_empty ? '0 : r_mem[r_rdPtr];
    assign data_avail = !w_empty;
    assign full       = w_full;
    assign ext_ready  = !w_full;

endmodule

// File: tb/tb_input_port_fifo.sv
// Directed testbench for input_port_fifo; the INPUT_PORT_SYNC_EN build runs the synchronizer sequence.
module tb_input_port_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       cpu_rd;
    logic [7:0] rd_data;
    logic       data_avail;
    logic       full;
    logic       overflow;
    logic       clr_overflow;

    int nChecks = 0;
    int nFails  = 0;

    input_port_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_data     (ext_data),
        .ext_valid    (ext_valid),
        .ext_ready    (ext_ready),
        .cpu_rd       (cpu_rd),
        .rd_data      (rd_data),
        .data_avail   (data_avail),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    // Drive inputs, let one rising edge pass, then settle 1ns before anything is sampled.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic rd);
        ext_valid = valid;
        ext_data  = data;
        cpu_rd    = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_avail"}, 32'(data_avail), 32'h0);
        checkOutput({tag, "_rd"}, 32'(rd_data), 32'h00);
    endtask

    initial begin
        reset        = 1'b1;
        ext_data     = 8'h00;
        ext_valid    = 1'b0;
        cpu_rd       = 1'b0;
        clr_overflow = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkEmpty("reset");
        checkOutput("reset_full", 32'(full), 32'h0);
        checkOutput("reset_ready", 32'(ext_ready), 32'h1);
        checkOutput("reset_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;

`ifdef INPUT_PORT_SYNC_EN
        // Single pulse: data_avail rises after the third edge.
        applyStimulus(1'b1, 8'hC3, 1'b0);
        checkOutput("sync_lat1", 32'(data_avail), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("sync_lat2", 32'(data_avail), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("sync_lat3", 32'(data_avail), 32'h1);
        checkOutput("sync_data", 32'(rd_data), 32'hC3);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("sync_pop");

        // Five pulses without pops: four are stored, the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0);
        end
        checkOutput("ovf_full", 32'(full), 32'h1);
        checkOutput("ovf_set", 32'(overflow), 32'h1);
        checkOutput("ovf_head", 32'(rd_data), 32'hD0);
        clr_overflow = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        clr_overflow = 1'b0;
        checkOutput("ovf_clr", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_drain", 32'(rd_data), 32'(8'hD0 + 8'(i)));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkEmpty("ovf_drained");
`else
        // Single byte in and out.
        applyStimulus(1'b1, 8'h0A, 1'b0);
        checkOutput("single_avail", 32'(data_avail), 32'h1);
        checkOutput("single_rd", 32'(rd_data), 32'h0A);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("single_pop");

        // Fill, hold a refused byte, pop one, then the held byte lands.
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("fill_full", 32'(full), 32'h1);
        checkOutput("fill_ready", 32'(ext_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h55, 1'b0);
            checkOutput("hold_head", 32'(rd_data), 32'h11);
            checkOutput("hold_full", 32'(full), 32'h1);
        end
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("popfull_rd", 32'(rd_data), 32'h22);
        checkOutput("popfull_ready", 32'(ext_ready), 32'h1);
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("accept55_full", 32'(full), 32'h1);
        checkOutput("drain0", 32'(rd_data), 32'h22);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain1", 32'(rd_data), 32'h33);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain2", 32'(rd_data), 32'h44);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain3", 32'(rd_data), 32'h55);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("drain_end");

        // Concurrent push and pop keep the count; pop on empty is ignored.
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b1);
        checkOutput("conc_head", 32'(rd_data), 32'hA2);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("conc_next", 32'(rd_data), 32'hA3);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("conc_empty");
        applyStimulus(1'b1, 8'h7E, 1'b1);
        checkOutput("emptyrd_avail", 32'(data_avail), 32'h1);
        checkOutput("emptyrd_rd", 32'(rd_data), 32'h7E);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("emptyrd_pop");

        // Interleaved traffic walks both pointers around the ring more than twice.
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("wrap0", 32'(rd_data), 32'h00);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1);
            checkOutput("wrap", 32'(rd_data), 32'(i));
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("wrap_end");

        // Reset with bytes queued and a byte offered: everything is discarded.
        applyStimulus(1'b1, 8'hB1, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0);
        applyStimulus(1'b1, 8'hB3, 1'b0);
        reset = 1'b1;
        applyStimulus(1'b1, 8'hB4, 1'b0);
        reset = 1'b0;
        checkEmpty("midreset");
        checkOutput("midreset_ready", 32'(ext_ready), 32'h1);
        applyStimulus(1'b1, 8'hC5, 1'b0);
        checkOutput("postreset_rd", 32'(rd_data), 32'hC5);
        checkOutput("postreset_full", 32'(full), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkEmpty("postreset_pop");
        clr_overflow = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        clr_overflow = 1'b0;
        checkOutput("ovf_tied", 32'(overflow), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
